// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Most negative two's-complement value for a given width, right-aligned.
    function automatic logic [63:0] signed_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_out,
    output logic             qbit
);

    logic [WIDTH+1:0] trial;

    // The extra top bit of trial is the borrow: set means the divisor did not fit.
    always_comb begin
        trial   = {1'b0, rem_in, bit_in} - {2'b00, div};
        qbit    = ~trial[WIDTH+1];
        rem_out = qbit ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], bit_in};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider, one restoring step per clock.
// SEQ_DIVIDER_REMAINDER_EN enables the remainder output; otherwise it reads 0.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_Div,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             except,
    output logic             ready,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake: ctrl_Div is accepted only in IDLE or DONE; busy is high from
    // the accepting edge through the ready cycle; ready pulses one cycle with
    // quotient/remainder/except valid, which then hold until the next result.

    localparam logic [63:0]      MIN_WIDE = signed_min(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = MIN_WIDE[WIDTH-1:0];

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] d_mag;
    logic             sign_a;
    logic             sign_b;
    logic             exc_pend;

    logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
    logic             b_zero, ovf;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    // Widened by one bit so the magnitude of the most negative value cannot wrap.
    always_comb begin
        a_ext  = {operandA[WIDTH-1], operandA};
        b_ext  = {operandB[WIDTH-1], operandB};
        a_mag  = operandA[WIDTH-1] ? (~a_ext + (WIDTH+1)'(1)) : a_ext;
        b_mag  = operandB[WIDTH-1] ? (~b_ext + (WIDTH+1)'(1)) : b_ext;
        b_zero = (operandB == '0);
        ovf    = (operandA == MIN_VAL) && (&operandB);
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (r_part),
        .bit_in  (q_sh[WIDTH-1]),
        .div     (d_mag),
        .rem_out (step_rem),
        .qbit    (step_bit)
    );

    assign dbg_state = state;

`ifndef SEQ_DIVIDER_REMAINDER_EN
    assign remainder = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            q_sh     <= '0;
            r_part   <= '0;
            d_mag    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            exc_pend <= 1'b0;
            quotient <= '0;
`ifdef SEQ_DIVIDER_REMAINDER_EN
            remainder <= '0;
`endif
            except   <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ctrl_Div) begin
                        busy   <= 1'b1;
                        cnt    <= '0;
                        r_part <= '0;
                        // Exceptions go straight to FIX with operands chosen so
                        // the sign correction yields the required result.
                        if (b_zero) begin
                            state    <= FIX;
                            exc_pend <= 1'b1;
                            q_sh     <= '0;
                            d_mag    <= '0;
                            sign_a   <= 1'b0;
                            sign_b   <= 1'b0;
                        end else begin
                            state    <= ovf ? FIX : RUN;
                            exc_pend <= ovf;
                            q_sh     <= a_mag[WIDTH-1:0];
                            d_mag    <= b_mag[WIDTH-1:0];
                            sign_a   <= operandA[WIDTH-1];
                            sign_b   <= operandB[WIDTH-1];
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(WIDTH)) begin
                        state <= FIX;
                    end else begin
                        r_part <= step_rem;
                        q_sh   <= {q_sh[WIDTH-2:0], step_bit};
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    state    <= DONE;
                    ready    <= 1'b1;
                    except   <= exc_pend;
                    quotient <= (sign_a ^ sign_b) ? -q_sh : q_sh;
`ifdef SEQ_DIVIDER_REMAINDER_EN
                    remainder <= sign_a ? -r_part : r_part;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32 and WIDTH=8 instances).
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_Div;
    logic [31:0] operandA, operandB;
    wire  [31:0] quotient, remainder;
    wire         except, ready, busy;
    wire  [1:0]  dbg_state;

    logic        ctrl_Div8;
    logic [7:0]  operandA8, operandB8;
    wire  [7:0]  quotient8, remainder8;
    wire         except8, ready8, busy8;
    wire  [1:0]  dbg_state8;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    always #5 clock = ~clock;

    seq_divider #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .ctrl_Div(ctrl_Div),
        .operandA(operandA), .operandB(operandB),
        .quotient(quotient), .remainder(remainder), .except(except),
        .ready(ready), .busy(busy), .dbg_state(dbg_state)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .ctrl_Div(ctrl_Div8),
        .operandA(operandA8), .operandB(operandB8),
        .quotient(quotient8), .remainder(remainder8), .except(except8),
        .ready(ready8), .busy(busy8), .dbg_state(dbg_state8)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] rexp(input logic [63:0] v);
`ifdef SEQ_DIVIDER_REMAINDER_EN
        return v;
`else
        return 64'd0;
`endif
    endfunction

    // Leaves the caller at the falling edge right after the accepting edge.
    task automatic start32(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_Div = 1'b1;
        operandA = a;
        operandB = b;
        @(negedge clock);
        ctrl_Div = 1'b0;
        operandA = $urandom;
        operandB = $urandom;
    endtask

    task automatic wait_ready32(input int limit, output int n);
        n = 0;
        while (!ready && n < limit) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] q, input logic [31:0] r, input logic e);
        int n;
        logic [63:0] eq, er, ee;
        exp_q.push_back({32'd0, q});
        exp_q.push_back(rexp({32'd0, r}));
        exp_q.push_back({63'd0, e});
        start32(a, b);
        chk({tag, "_busy"}, busy, 1);
        wait_ready32(60, n);
        chk({tag, "_lat"}, n, lat);
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        ee = exp_q.pop_front();
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_exc"}, except, ee);
        @(negedge clock);
        chk({tag, "_pulse"}, ready, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_qhold"}, quotient, eq);
    endtask

    initial begin
        int n;
        int seen;
        reset_n   = 1'b0;
        ctrl_Div  = 1'b0;
        operandA  = '0;
        operandB  = '0;
        ctrl_Div8 = 1'b0;
        operandA8 = '0;
        operandB8 = '0;
        #12;
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_exc", except, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        run32("a2_bm5", 32'd2, -32'sd5, 34, 32'd0, 32'd2, 1'b0);
        run32("a7_b3", 32'd7, 32'd3, 34, 32'd2, 32'd1, 1'b0);
        run32("am7_b2", -32'sd7, 32'd2, 34, -32'sd3, -32'sd1, 1'b0);

        // Second start mid-RUN must be ignored.
        start32(32'd1000, 32'd9);
        repeat (4) @(negedge clock);
        ctrl_Div = 1'b1;
        operandA = 32'd50;
        operandB = 32'd5;
        @(negedge clock);
        ctrl_Div = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_state", dbg_state, 1);
        wait_ready32(60, n);
        chk("restart_lat", n + 5, 34);
        chk("restart_q", quotient, 111);
        chk("restart_r", remainder, rexp(1));
        @(negedge clock);
        chk("restart_pulse", ready, 0);
        chk("restart_idle", busy, 0);

        run32("div0", 32'd123, 32'd0, 1, 32'd0, 32'd0, 1'b1);
        run32("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'd0, 1'b1);

        // Reset during RUN clears held outputs at once and aborts.
        start32(32'd555, 32'd4);
        repeat (9) @(negedge clock);
        chk("midrun_qhold", quotient, 32'h8000_0000);
        chk("midrun_exchold", except, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_q", quotient, 0);
        chk("arst_exc", except, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", ready, 0);
        chk("arst_state", dbg_state, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (ready) seen++;
        end
        chk("arst_noready", seen, 0);
        run32("a100_b7", 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);

        // Narrow build: most-negative dividend.
        @(negedge clock);
        ctrl_Div8 = 1'b1;
        operandA8 = 8'h80;
        operandB8 = 8'd3;
        @(negedge clock);
        ctrl_Div8 = 1'b0;
        operandA8 = 8'h11;
        n = 0;
        while (!ready8 && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk("w8_lat", n, 10);
        chk("w8_q", quotient8, 8'hD6);
        chk("w8_r", remainder8, rexp(8'hFE));
        chk("w8_exc", except8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 4..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), iteration counter width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ctrl_Div  input  1  start request, sampled on rising edge.
REQ-006 SHALL have port operandA  input  WIDTH  signed dividend, sampled with accepted ctrl_Div.
REQ-007 SHALL have port operandB  input  WIDTH  signed divisor, sampled with accepted ctrl_Div.
REQ-008 SHALL have port quotient  output  WIDTH  signed quotient, held until next accepted start.
REQ-009 SHALL have port remainder  output  WIDTH  signed remainder (see REQ-029).
REQ-010 SHALL have port except  output  1  divide-by-zero or overflow flag, valid while ready=1 and held after.
REQ-011 SHALL have port ready  output  1  single-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high from accepted start until ready pulse inclusive.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX, DONE.
REQ-014 IDLE: ctrl_Div=1 at an edge SHALL capture operands, magnitudes and signs, and go to RUN (counter=0); DONE behaves as IDLE for start acceptance.
REQ-015 ctrl_Div while busy=1 and not in DONE SHALL be ignored; operand changes during RUN SHALL not affect the result.
REQ-016 RUN SHALL perform one radix-2 restoring step on unsigned magnitudes per cycle, exactly WIDTH cycles, then go to FIX.
REQ-017 FIX SHALL apply sign correction in one cycle, then go to DONE.
REQ-018 DONE SHALL assert ready for exactly one cycle, then go to IDLE unless a new start is accepted on that edge.
REQ-019 Normal latency: start accepted at edge k SHALL give ready=1 in the cycle after edge k+WIDTH+2.
REQ-020 Quotient SHALL truncate toward zero; remainder sign SHALL equal dividend sign; quotient*B+remainder=A.
REQ-021 operandB=0 SHALL skip RUN/FIX, go to DONE at edge k+1: quotient=0, remainder=0, except=1.
REQ-022 operandA=-2^(WIDTH-1), operandB=-1 SHALL skip RUN/FIX, go to DONE at edge k+1: quotient=-2^(WIDTH-1), remainder=0, except=1.
REQ-023 All other cases SHALL produce except=0.
REQ-024 quotient/remainder/except SHALL update only on entry to DONE and hold through IDLE.
REQ-025 Magnitude of -2^(WIDTH-1) SHALL be handled in WIDTH+1-bit arithmetic without wrap.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, counter=0, quotient=0, remainder=0, except=0, ready=0, busy=0.
REQ-027 Reset mid-RUN SHALL abort the operation with no ready pulse; first start after release SHALL behave as from power-up.

Configuration
REQ-028 Macro SEQ_DIVIDER_REMAINDER_EN SHALL control remainder output logic.
REQ-029 Defined: remainder per REQ-020..022. Undefined: remainder tied to 0, partial-remainder sign correction removed, quotient/timing unchanged.

Structure
REQ-030 Shared package div_pkg SHALL hold the state enum (IDLE, RUN, FIX, DONE) and a function for the signed-min constant per width.
REQ-031 One sub-module div_step SHALL implement one combinational restoring step (partial remainder, divisor -> next remainder, quotient bit), parameterised by WIDTH.

Verification
REQ-032 WIDTH=32, A=2, B=-5, start one cycle -> ready after 34 cycles, quotient=0, remainder=2, except=0.
REQ-033 A=7, B=3 -> quotient=2, remainder=1; A=-7, B=2 -> quotient=-3, remainder=-1; except=0.
REQ-034 A=123, B=0 -> ready after 1 cycle, quotient=0, remainder=0, except=1; then A=-2147483648, B=-1 -> quotient=-2147483648, except=1.
REQ-035 Start, ctrl_Div pulsed again with new operands at cycle 5 -> ignored, single ready at cycle 34 with first result.
REQ-036 reset_n low at cycle 10 of RUN -> outputs 0 immediately, no ready; restart A=100, B=7 -> quotient=14, remainder=2.
REQ-037 WIDTH=8 build, A=-128, B=3 -> ready after 10 cycles, quotient=-42, remainder=-2; with macro undefined remainder=0.
